// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the sequential FIR filter.
// Holds the controller state encoding and the reset-time coefficient set.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Every tap resets to 1, so an unprogrammed filter is a moving sum.
    function automatic int default_coef();
        return 1;
    endfunction

endpackage

// File: rtl/fir_seq_mac.sv
// Signed multiply-accumulate unit with synchronous clear/enable and a
// floor-shifted, saturated view of the accumulator.
module fir_seq_mac
    import fir_seq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int NTAPS     = 8,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [COEF_W-1:0] c_i,
    output logic [OUT_W-1:0]  result_o
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(NTAPS);
    localparam int WIDE_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_shifted;
    logic signed [WIDE_W-1:0] acc_wide;

    assign prod        = $signed(x_i) * $signed(c_i);
    assign acc_d       = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_shifted = acc_q >>> OUT_SHIFT;
    // Widen by one bit so the saturation bounds are representable for any OUT_W.
    assign acc_wide    = {{(WIDE_W-ACC_W){acc_shifted[ACC_W-1]}}, acc_shifted};

    always_comb begin
        if (acc_wide > SAT_MAX) begin
            result_o = SAT_MAX[OUT_W-1:0];
        end else if (acc_wide < SAT_MIN) begin
            result_o = SAT_MIN[OUT_W-1:0];
        end else begin
            result_o = acc_wide[OUT_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_seq.sv
// Time-multiplexed FIR filter: one MAC per cycle over NTAPS taps, with a
// programmable coefficient bank, sample-drop detection and sticky overrun.
module fir_seq
    import fir_seq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int NTAPS     = 8,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample,
    input  logic [DATA_W-1:0]        sample_in,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     clr_ovr,
    output logic                     ready,
    output logic [OUT_W-1:0]         data_out,
    output logic                     out_valid,
    output logic                     overrun
);

    localparam int IDX_W = $clog2(NTAPS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] x_q    [NTAPS];
    logic [COEF_W-1:0] coef_q [NTAPS];
    logic [OUT_W-1:0] data_out_q;
    logic [OUT_W-1:0] mac_result;
    logic             out_valid_q;
    logic             overrun_q, overrun_d;
    logic             accept, mac_clr, mac_en, load_out, busy_req;

    assign ready     = (state_q == IDLE);
    assign busy_req  = (sample | coef_we) & ~ready;
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        accept   = 1'b0;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        load_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample) begin
                    accept  = 1'b1;
                    mac_clr = 1'b1;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == IDX_W'(NTAPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                load_out = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A drop on the same edge as a clear wins, so no overrun is ever lost.
    always_comb begin
        overrun_d = overrun_q;
        if (busy_req) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= load_out;
            overrun_q   <= overrun_d;
            if (load_out) begin
                data_out_q <= mac_result;
            end
        end
    end

    // NOTE: these arrays are flops, not RAM, because their reset contents
    // (zeroed history, default taps) are visible behaviour; a RAM would not reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k]    <= '0;
                coef_q[k] <= COEF_W'(default_coef());
            end
        end else begin
            if (accept) begin
                x_q[0] <= sample_in;
                for (int k = 1; k < NTAPS; k++) begin
                    x_q[k] <= x_q[k-1];
                end
            end
            for (int k = 0; k < NTAPS; k++) begin
                if (coef_we && ready && coef_addr == IDX_W'(k)) begin
                    coef_q[k] <= coef_data;
                end
            end
        end
    end

    fir_seq_mac #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .NTAPS     (NTAPS),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (mac_clr),
        .en_i     (mac_en),
        .x_i      (x_q[idx_q]),
        .c_i      (coef_q[idx_q]),
        .result_o (mac_result)
    );

endmodule

// File: tb/tb_fir_seq.sv
// Scoreboard bench for fir_seq: two instances (OUT_SHIFT 0 and 2) share one
// stimulus stream; a reference model predicts results, a monitor checks them.
module tb_fir_seq;

    localparam int NTAPS = 4;
    localparam int OUT_W = 16;
    localparam int LAT   = NTAPS + 1;
    localparam int GAP   = NTAPS + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample = 1'b0;
    logic [7:0]  sample_in = '0;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [7:0]  coef_data = '0;
    logic        clr_ovr = 1'b0;
    logic        ready0, ready2, ov0, ov2, ovr0, ovr2;
    logic [15:0] d0, d2;

    typedef struct {
        int y0;
        int y2;
        int edge_n;
    } exp_t;

    exp_t sb[$];
    int   mx[NTAPS];
    int   mc[NTAPS];
    int   next_free;
    bit   m_ovr;
    bit   prev_v;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fir_seq #(.DATA_W(8), .COEF_W(8), .NTAPS(NTAPS), .OUT_W(OUT_W), .OUT_SHIFT(0)) u_dut0 (
        .clk(clk), .reset(reset), .sample(sample), .sample_in(sample_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .clr_ovr(clr_ovr),
        .ready(ready0), .data_out(d0), .out_valid(ov0), .overrun(ovr0)
    );

    fir_seq #(.DATA_W(8), .COEF_W(8), .NTAPS(NTAPS), .OUT_W(OUT_W), .OUT_SHIFT(2)) u_dut2 (
        .clk(clk), .reset(reset), .sample(sample), .sample_in(sample_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .clr_ovr(clr_ovr),
        .ready(ready2), .data_out(d2), .out_valid(ov2), .overrun(ovr2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sd(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Floor shift then clamp to the signed output range.
    function automatic int sat_shift(input int y, input int s);
        int v;
        int hi;
        v  = y >>> s;
        hi = (1 << (OUT_W - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            mx[k] = 0;
            mc[k] = 1;
        end
        m_ovr     = 1'b0;
        next_free = 0;
        sb.delete();
    endtask

    // Drive one cycle starting just after a rising edge; the model decides
    // acceptance purely from its own record of when the filter frees up.
    task automatic cycle(input bit smp, input int sin, input bit we, input int addr,
                         input int cdat, input bit clr);
        int e;
        bit idle;
        bit drop;
        int y;
        e    = cyc + 1;
        idle = (e >= next_free);
        drop = !idle && (smp || we);
        sample    = smp;
        sample_in = 8'(sin);
        coef_we   = we;
        coef_addr = 2'(addr);
        coef_data = 8'(cdat);
        clr_ovr   = clr;
        check("ready0", int'(ready0), int'(idle));
        check("ready2", int'(ready2), int'(idle));
        if (idle) begin
            if (we) mc[addr] = cdat;
            if (smp) begin
                for (int k = NTAPS - 1; k > 0; k--) mx[k] = mx[k-1];
                mx[0] = sin;
                y = 0;
                for (int k = 0; k < NTAPS; k++) y += mx[k] * mc[k];
                sb.push_back('{sat_shift(y, 0), sat_shift(y, 2), e});
                next_free = e + GAP;
            end
        end
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        @(posedge clk);
        #1;
        sample  = 1'b0;
        coef_we = 1'b0;
        clr_ovr = 1'b0;
        check("overrun0", int'(ovr0), int'(m_ovr));
        check("overrun2", int'(ovr2), int'(m_ovr));
    endtask

    task automatic idle_n(input int n);
        repeat (n) cycle(1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic send(input int s);
        cycle(1'b1, s, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) idle_n(1);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #2;
        check("rst_data0", sd(d0), 0);
        check("rst_data2", sd(d2), 0);
        check("rst_valid", int'(ov0 | ov2), 0);
        check("rst_overrun", int'(ovr0 | ovr2), 0);
        check("rst_ready", int'(ready0 & ready2), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every out_valid must match the oldest prediction, in both
    // instances, at the exact latency and as a single-cycle pulse.
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (ov0 || ov2) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", int'(ov0 | ov2), 0);
                end else begin
                    exp_t ex;
                    ex = sb.pop_front();
                    check("out_valid0", int'(ov0), 1);
                    check("out_valid2", int'(ov2), 1);
                    check("data_out0", sd(d0), ex.y0);
                    check("data_out2", sd(d2), ex.y2);
                    check("latency", cyc - ex.edge_n, LAT);
                    check("valid_pulse", int'(prev_v), 0);
                end
            end
            prev_v = ov0 | ov2;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        do_reset();

        // Moving sum, back-to-back at maximum throughput.
        send(10); idle_n(GAP - 1);
        send(20); idle_n(GAP - 1);
        send(30); idle_n(GAP - 1);
        send(40);
        drain();
        check("moving_sum_last", sd(d0), 100);

        // Coefficient write coinciding with a sample uses the new tap.
        do_reset();
        cycle(1'b1, 7, 1'b1, 3, -2, 1'b0);
        idle_n(GAP - 1);
        check("coef_first_out", sd(d0), 7);
        send(0); idle_n(GAP - 1);
        send(0); idle_n(GAP - 1);
        send(0);
        drain();
        check("coef_tap3_out", sd(d0), -14);

        // Saturation at both rails.
        for (int a = 0; a < NTAPS; a++) cycle(1'b0, 0, 1'b1, a, 127, 1'b0);
        for (int i = 0; i < NTAPS; i++) begin send(127); idle_n(GAP - 1); end
        drain();
        check("sat_pos0", sd(d0), 32767);
        check("sat_pos2", sd(d2), 16129);
        for (int i = 0; i < NTAPS; i++) begin send(-128); idle_n(GAP - 1); end
        drain();
        check("sat_neg0", sd(d0), -32768);
        check("sat_neg2", sd(d2), -16256);

        // Floor behaviour of the arithmetic shift.
        do_reset();
        for (int i = 0; i < NTAPS; i++) begin send(-1); idle_n(GAP - 1); end
        drain();
        check("floor_shift2", sd(d2), -1);
        check("floor_shift0", sd(d0), -4);

        // Overrun: dropped sample, ignored busy write, clear, clear-vs-drop.
        do_reset();
        send(3); idle_n(2);
        send(99);
        idle_n(1);
        cycle(1'b0, 0, 1'b1, 0, 50, 1'b0);
        drain();
        check("drop_result", sd(d0), 3);
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
        send(2); idle_n(1);
        cycle(1'b1, 9, 1'b0, 0, 0, 1'b1);
        drain();
        check("drop_result2", sd(d0), 5);
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);

        // Reset mid-MAC aborts without a result.
        send(9); idle_n(2);
        do_reset();
        idle_n(GAP);
        send(5);
        drain();
        check("after_abort", sd(d0), 5);

        // Randomised mix of samples, writes, clears and short gaps.
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            cycle(r < 7, int'($urandom_range(0, 255)) - 128, r >= 5,
                  int'($urandom_range(0, NTAPS - 1)), int'($urandom_range(0, 255)) - 128,
                  r == 9);
            idle_n(int'($urandom_range(0, 6)));
        end
        drain();
        idle_n(2);
        check("final_queue_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_seq.md
FIR_SEQ -- requirements
Module: fir_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 8, meaning signed coefficient width.
REQ-003 SHALL have parameter NTAPS, default 8, meaning tap count (2..64).
REQ-004 SHALL have parameter OUT_W, default 16, meaning signed output width.
REQ-005 SHALL have parameter OUT_SHIFT, default 0, meaning arithmetic right shift applied before saturation.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk in 1 system clock; reset in 1 async active-high reset.
REQ-007 SHALL have port sample in 1, meaning new-sample strobe.
REQ-008 SHALL have port sample_in in DATA_W, meaning signed sample, qualified by sample.
REQ-009 SHALL have ports coef_we in 1, coef_addr in $clog2(NTAPS), and coef_data in COEF_W, meaning the coefficient write port.
REQ-010 SHALL have port clr_ovr in 1, meaning clear the overrun flag.
REQ-011 SHALL have port ready out 1, meaning idle and able to accept a sample or coefficient write.
REQ-012 SHALL have port data_out out OUT_W, meaning signed filtered result, held until the next result.
REQ-013 SHALL have port out_valid out 1, meaning one-cycle pulse when data_out updates.
REQ-014 SHALL have port overrun out 1, meaning sticky flag: a sample was dropped.

Function
REQ-015 SHALL implement y[n] = sum over k=0..NTAPS-1 of c[k]*x[n-k], computed by one time-multiplexed multiply-accumulate unit at one tap per cycle.
REQ-016 SHALL have FSM states IDLE, MAC, and DONE; ready = (state==IDLE).
REQ-017 SHALL, in IDLE with sample=1 at edge E0: shift the delay line (x[0]<=sample_in, x[k]<=x[k-1]), clear acc and the tap index, and go to MAC.
REQ-018 SHALL, in MAC, at each edge: acc += x[idx]*c[idx] and idx++; after the edge adding tap NTAPS-1 (E_NTAPS), go to DONE.
REQ-019 SHALL, in DONE at edge E_NTAPS+1: load data_out, set out_valid=1 for exactly one cycle, and return to IDLE; latency is NTAPS+1 cycles from the accepting edge.
REQ-020 SHALL allow a new sample to be accepted in the cycle after out_valid, giving back-to-back throughput of one sample per NTAPS+2 cycles.
REQ-021 SHALL use a signed product of DATA_W+COEF_W bits and an accumulator of DATA_W+COEF_W+$clog2(NTAPS) bits; the accumulator never overflows.
REQ-022 SHALL form the output as acc >>> OUT_SHIFT (floor), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-023 SHALL, on sample=1 while ready=0, drop the sample, leave the delay line unchanged, and set overrun=1 at the next edge.
REQ-024 SHALL, on clr_ovr=1, clear overrun at the next edge; simultaneous clr_ovr and a new drop leave overrun=1.
REQ-025 SHALL accept coef_we only when ready=1 (c[coef_addr]<=coef_data); a write while busy is ignored and sets overrun.
REQ-026 SHALL, when sample and coef_we are both asserted in IDLE, perform the coefficient write first; the new coefficient is used for that sample's computation.

Reset
REQ-027 SHALL, on reset assertion at any time, immediately force: state IDLE, delay line 0, acc 0, idx 0, data_out 0, out_valid 0, overrun 0, and coefficients to the package default.
REQ-028 SHALL abort any computation in progress when reset is asserted mid-MAC, with no out_valid pulse produced.
REQ-029 SHALL release reset asynchronously in assertion only; the first sample is accepted on the first clk edge after reset deasserts.

Structure
REQ-030 SHALL use package fir_seq_pkg to hold the FSM state enum and the default-coefficient function (all taps = 1, moving sum).
REQ-031 SHALL use sub-module fir_seq_mac, a signed multiply-accumulate unit with clear, enable, and saturating shift output; the top level holds the FSM, delay line, and coefficient registers.

Verification
REQ-032 SHALL verify, with DATA_W=8, NTAPS=4, default coefficients and OUT_SHIFT=0, that samples 10,20,30,40 -> data_out 10,30,60,100, each out_valid exactly 5 cycles after its sample edge.
REQ-033 SHALL verify, with OUT_W=16 and all coefficients written to 127, that four samples of 127 -> final output 32767 (saturated), and four samples of -128 -> -32768.
REQ-034 SHALL verify that OUT_SHIFT=2 with default coefficients and samples -1,-1,-1,-1 -> final output -1 (floor of -4>>>2).
REQ-035 SHALL verify that a sample pulse during MAC -> sample dropped, result unchanged, overrun=1; then clr_ovr -> overrun=0.
REQ-036 SHALL verify that reset asserted 2 cycles into MAC -> no out_valid, all outputs 0, and a following sample of 5 -> data_out 5.
REQ-037 SHALL verify that coef_we with addr 3 and data -2 together with sample=7 in IDLE (delay line otherwise 0) -> data_out 7, then three zero samples -> the last output is -14.
